regfl_2r1w: RTL



---
 rtl/regfl_pkg.sv | 12 +
 rtl/regfl_rdport.sv | 70 +++++++
 rtl/regfl_2r1w.sv | 88 ++++++++
 3 files changed

// File: rtl/regfl_pkg.sv
// Shared constants and helpers for the 2-read/1-write register file.
package regfl_pkg;

   localparam int REGFL_W  = 8;
   localparam int REGFL_AW = 2;

   // Number of entries addressable with an aw-bit address.
   function automatic int regfl_depth(input int aw);
      return 2 ** aw;
   endfunction

endpackage

// File: rtl/regfl_rdport.sv
// One registered read port of the register file: read mux over the entry
// array, registered data plus a one-cycle valid flag.
// Build option: define REGFL_BYPASS_EN for write-first forwarding on a
// read/write address collision; left undefined the port is read-first.
module regfl_rdport
   import regfl_pkg::*;
#(
   parameter  int W     = REGFL_W,
   parameter  int AW    = REGFL_AW,
   localparam int DEPTH = regfl_depth(AW)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  wr_e_i,
   input  logic [AW-1:0]         wr_addr_i,
   input  logic [W-1:0]          wr_data_i,
   input  logic                  rd_e_i,
   input  logic [AW-1:0]         rd_addr_i,
   input  logic [DEPTH-1:0][W-1:0] entries_i,
   output logic [W-1:0]          rd_data_o,
   output logic                  rd_valid_o
);

   logic [W-1:0] readValue;
   logic [W-1:0] rdData_d;
   logic [W-1:0] rdData_q;
   logic         rdValid_d;
   logic         rdValid_q;

`ifdef REGFL_BYPASS_EN
   // Select the stored entry, or forward the write data when this edge writes
   // the same address; a clear drops the write, so nothing is forwarded then.
   always_comb begin
      readValue = entries_i[rd_addr_i];
      if (wr_e_i && !clr_i && (wr_addr_i == rd_addr_i)) begin
         readValue = wr_data_i;
      end
   end
`else
   // Read-first: always return the pre-edge contents of the addressed entry.
   always_comb begin
      readValue = entries_i[rd_addr_i];
   end

   logic unusedBypassInputs;
   assign unusedBypassInputs = ^{clr_i, wr_e_i, wr_addr_i, wr_data_i};
`endif

   // Load new data only on a read; valid mirrors the read enable of this edge.
   always_comb begin
      rdData_d  = rd_e_i ? readValue : rdData_q;
      rdValid_d = rd_e_i;
   end

   // Output registers, cleared immediately by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdData_q  <= '0;
         rdValid_q <= 1'b0;
      end else begin
         rdData_q  <= rdData_d;
         rdValid_q <= rdValid_d;
      end
   end

   assign rd_data_o  = rdData_q;
   assign rd_valid_o = rdValid_q;

endmodule

// File: rtl/regfl_2r1w.sv
// Parametrised register file with one write port and two registered read
// ports; operand store for the lab datapath.
// Build option: REGFL_BYPASS_EN selects write-first forwarding in the read
// ports (see regfl_rdport); the default build is read-first.
module regfl_2r1w
   import regfl_pkg::*;
#(
   parameter int W  = REGFL_W,
   parameter int AW = REGFL_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          wr_e,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_e_a,
   input  logic          rd_e_b,
   input  logic [AW-1:0] rd_addr_a,
   input  logic [AW-1:0] rd_addr_b,
   output logic [W-1:0]  rd_data_a,
   output logic [W-1:0]  rd_data_b,
   output logic          rd_valid_a,
   output logic          rd_valid_b
);

   localparam int DEPTH = regfl_depth(AW);

   logic [DEPTH-1:0][W-1:0] entries;
   logic [DEPTH-1:0]        entryLoad;

   for (genvar i = 0; i < DEPTH; i++) begin : gEntry
      logic [W-1:0] value_d;
      logic [W-1:0] value_q;

      assign entryLoad[i] = wr_e && (wr_addr == AW'(i));

      // Clear beats a simultaneous write; otherwise load on an address match.
      always_comb begin
         value_d = value_q;
         if (clr) begin
            value_d = '0;
         end else if (entryLoad[i]) begin
            value_d = wr_data;
         end
      end

      // Entry storage, cleared immediately by reset.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            value_q <= '0;
         end else begin
            value_q <= value_d;
         end
      end

      assign entries[i] = value_q;
   end

   regfl_rdport #(.W(W), .AW(AW)) uPortA (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (clr),
      .wr_e_i     (wr_e),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rd_e_i     (rd_e_a),
      .rd_addr_i  (rd_addr_a),
      .entries_i  (entries),
      .rd_data_o  (rd_data_a),
      .rd_valid_o (rd_valid_a)
   );

   regfl_rdport #(.W(W), .AW(AW)) uPortB (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (clr),
      .wr_e_i     (wr_e),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .rd_e_i     (rd_e_b),
      .rd_addr_i  (rd_addr_b),
      .entries_i  (entries),
      .rd_data_o  (rd_data_b),
      .rd_valid_o (rd_valid_b)
   );

endmodule
